// File: rtl/branch_predictor_if.sv
// FD lookup / X update bus between the core control logic and the branch predictor.
// The core drives PCs and outcomes; the predictor returns the FD prediction.
interface branch_predictor_if;
    logic [31:0] pc_guess;
    logic        is_br_guess;
    logic        pred_taken;
    logic        hit_guess;
    logic [31:0] pc_check;
    logic        is_br_check;
    logic        br_taken_check;

    modport master (
        output pc_guess, is_br_guess, pc_check, is_br_check, br_taken_check,
        input  pred_taken, hit_guess
    );

    modport slave (
        input  pc_guess, is_br_guess, pc_check, is_br_check, br_taken_check,
        output pred_taken, hit_guess
    );
endinterface

// File: rtl/branch_predictor.sv
// Tagged direct-mapped table of 2-bit saturating counters: combinational FD lookup,
// X-stage training on the clock edge. Held in flops so the lookup is asynchronous.
module branch_predictor #(
    parameter int LINES = 8
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    logic            valid_reg [LINES];
    logic [TAGW-1:0] tag_reg   [LINES];
    logic [1:0]      ctr_reg   [LINES];

    logic [IDX-1:0]  guess_idx;
    logic [TAGW-1:0] guess_tag;
    logic [IDX-1:0]  check_idx;
    logic [TAGW-1:0] check_tag;
    logic            check_hit;
    logic [1:0]      ctr_next;
    logic [LINES-1:0] wr_en;
    logic            unused_low_bits;

    assign guess_idx = bp.pc_guess[IDX+1:2];
    assign guess_tag = bp.pc_guess[31:IDX+2];
    assign check_idx = bp.pc_check[IDX+1:2];
    assign check_tag = bp.pc_check[31:IDX+2];
    assign unused_low_bits = ^{bp.pc_guess[1:0], bp.pc_check[1:0]};

    // Lookup sees the pre-update table; there is deliberately no write bypass.
    assign bp.hit_guess  = bp.is_br_guess && valid_reg[guess_idx]
                           && (tag_reg[guess_idx] == guess_tag);
    assign bp.pred_taken = bp.hit_guess && ctr_reg[guess_idx][1];

    assign check_hit = valid_reg[check_idx] && (tag_reg[check_idx] == check_tag);

    always_comb begin
        ctr_next = ctr_reg[check_idx];
        if (!check_hit) begin
            ctr_next = bp.br_taken_check ? 2'b10 : 2'b01;
        end else if (bp.br_taken_check) begin
            if (ctr_reg[check_idx] != 2'b11) ctr_next = ctr_reg[check_idx] + 2'b01;
        end else begin
            if (ctr_reg[check_idx] != 2'b00) ctr_next = ctr_reg[check_idx] - 2'b01;
        end
    end

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_wr_en
            assign wr_en[gi] = bp.is_br_check && (check_idx == IDX'(gi));
        end
    endgenerate

    // A miss simply overwrites the indexed entry (allocation and training share one path).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                valid_reg[i] <= 1'b0;
                tag_reg[i]   <= '0;
                ctr_reg[i]   <= 2'b00;
            end
        end else begin
            for (int i = 0; i < LINES; i++) begin
                if (wr_en[i]) begin
                    valid_reg[i] <= 1'b1;
                    tag_reg[i]   <= check_tag;
                    ctr_reg[i]   <= ctr_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against a behavioural table model.
module tb_branch_predictor;
    localparam int LINES = 8;
    localparam int IDX   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

    branch_predictor #(.LINES(LINES)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if.slave)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: per index, whether an entry exists, the PC tag it holds,
    // and the counter as a plain integer 0..3 (>=2 means predict taken).
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    int          m_ctr   [LINES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % LINES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (IDX + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_ctr[i]   = 0;
        end
    endtask

    task automatic model_update(input logic [31:0] pc, input logic taken);
        int unsigned k;
        k = idx_of(pc);
        if (m_valid[k] && m_tag[k] == tag_of(pc)) begin
            m_ctr[k] = taken ? ((m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1)
                             : ((m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1);
        end else begin
            m_valid[k] = 1'b1;
            m_tag[k]   = tag_of(pc);
            m_ctr[k]   = taken ? 2 : 1;
        end
    endtask

    // One cycle: drive, compare outputs mid-cycle against the pre-edge model, then advance.
    task automatic step(input logic [31:0] pcg, input logic isg,
                        input logic [31:0] pcc, input logic isc, input logic tk,
                        input logic r, output logic obs_hit, output logic obs_pred);
        logic exp_hit, exp_pred;
        int unsigned k;
        bp_if.pc_guess       = pcg;
        bp_if.is_br_guess    = isg;
        bp_if.pc_check       = pcc;
        bp_if.is_br_check    = isc;
        bp_if.br_taken_check = tk;
        rst                  = r;
        @(negedge clk);
        k        = idx_of(pcg);
        exp_hit  = isg && m_valid[k] && (m_tag[k] == tag_of(pcg));
        exp_pred = exp_hit && (m_ctr[k] >= 2);
        obs_hit  = bp_if.hit_guess;
        obs_pred = bp_if.pred_taken;
        check("hit_model",  {31'b0, obs_hit},  {31'b0, exp_hit});
        check("pred_model", {31'b0, obs_pred}, {31'b0, exp_pred});
        $display("txn %0d rst=%0b guess pc=%08h br=%0b -> hit=%0b pred=%0b | check pc=%08h br=%0b tk=%0b",
                 txn, r, pcg, isg, obs_hit, obs_pred, pcc, isc, tk);
        txn++;
        @(posedge clk);
        if (r) model_reset();
        else if (isc) model_update(pcc, tk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk);
        logic h, p;
        step(pc, 1'b1, pc, 1'b1, tk, 1'b0, h, p);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic isg,
                        input logic exp_hit, input logic exp_pred);
        logic h, p;
        step(pc, isg, 32'h0, 1'b0, 1'b0, 1'b0, h, p);
        check({tag, "_hit"},  {31'b0, h}, {31'b0, exp_hit});
        check({tag, "_pred"}, {31'b0, p}, {31'b0, exp_pred});
    endtask

    initial begin
        logic h, p;
        logic [31:0] pcg, pcc;
        bp_if.pc_guess       = 32'h0;
        bp_if.is_br_guess    = 1'b0;
        bp_if.pc_check       = 32'h0;
        bp_if.is_br_check    = 1'b0;
        bp_if.br_taken_check = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        look("cold", 32'h1000_0040, 1'b1, 1'b0, 1'b0);

        upd(32'h1000_0040, 1'b1);
        look("alloc_t", 32'h1000_0040, 1'b1, 1'b1, 1'b1);
        upd(32'h1000_0040, 1'b0);
        upd(32'h1000_0040, 1'b0);
        look("train_00", 32'h1000_0040, 1'b1, 1'b1, 1'b0);
        upd(32'h1000_0040, 1'b1);
        look("train_01", 32'h1000_0040, 1'b1, 1'b1, 1'b0);

        // Counter now 01: lookup and taken update in the same cycle.
        step(32'h1000_0040, 1'b1, 32'h1000_0040, 1'b1, 1'b1, 1'b0, h, p);
        check("collide_now", {31'b0, p}, 32'h0);
        look("collide_next", 32'h1000_0040, 1'b1, 1'b1, 1'b1);

        repeat (5) upd(32'h2000_0044, 1'b1);
        upd(32'h2000_0044, 1'b0);
        look("saturate", 32'h2000_0044, 1'b1, 1'b1, 1'b1);

        repeat (3) upd(32'h0000_0020, 1'b1);
        look("alias_pre", 32'h0000_0020, 1'b1, 1'b1, 1'b1);
        upd(32'h0000_0420, 1'b0);
        look("alias_old", 32'h0000_0020, 1'b1, 1'b0, 1'b0);
        look("alias_new", 32'h0000_0420, 1'b1, 1'b1, 1'b0);

        look("gate_guess", 32'h2000_0044, 1'b0, 1'b0, 1'b0);
        repeat (3) step(32'h0000_0420, 1'b1, 32'h0000_0420, 1'b0, 1'b1, 1'b0, h, p);
        look("gate_check", 32'h0000_0420, 1'b1, 1'b1, 1'b0);

        step(32'h2000_0044, 1'b1, 32'h2000_0044, 1'b1, 1'b1, 1'b1, h, p);
        look("rst_upd_a", 32'h2000_0044, 1'b1, 1'b0, 1'b0);
        look("rst_upd_b", 32'h0000_0420, 1'b1, 1'b0, 1'b0);

        // Small tag/index pool so hits, aliasing and collisions all recur.
        for (int n = 0; n < 400; n++) begin
            pcg = ($urandom_range(0, 2) << (IDX + 2)) | ($urandom_range(0, LINES - 1) << 2)
                  | $urandom_range(0, 3);
            pcc = ($urandom_range(0, 2) << (IDX + 2)) | ($urandom_range(0, LINES - 1) << 2)
                  | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) pcc = pcg;
            step(pcg, ($urandom_range(0, 7) != 0), pcc, ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1), ($urandom_range(0, 99) == 0), h, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
